hack_pc: RTL and testbench
==========================

HACK_PC -- requirements
Module: hack_pc

Interface
REQ-001 Parameter ADDR_W, default 15, program-counter width (32K-word ROM).
REQ-002 Parameter RESET_ADDR, default 0, value loaded on any reset.
REQ-003 Parameter CNT_W, default 16, width of retired-instruction counter.
REQ-004 clk_in  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 soft_rst_in  input  1  synchronous reset request (Hack "reset" button).
REQ-007 en_in  input  1  advance enable; 0 = stall, all state held.
REQ-008 is_c_inst_in  input  1  current instruction is a C-instruction.
REQ-009 jump_bits_in  input  3  j1 j2 j3 of current instruction (lt, eq, gt).
REQ-010 zr_in  input  1  ALU output zero flag.
REQ-011 ng_in  input  1  ALU output negative flag.
REQ-012 target_in  input  ADDR_W  jump target (A-register low bits).
REQ-013 pc_out  output  ADDR_W  registered instruction address.
REQ-014 jump_taken_out  output  1  registered, high one cycle after an accepted taken jump.
REQ-015 halted_out  output  1  sticky, self-loop detected.
REQ-016 retired_out  output  CNT_W  count of accepted advances, saturating.

Function
REQ-017 take = is_c_inst_in & ((j1 & ng_in) | (j2 & zr_in) | (j3 & ~zr_in & ~ng_in)), combinational.
REQ-018 Per-cycle priority: soft_rst_in > ~en_in (hold) > halted_out (hold) > take (load) > increment.
REQ-019 soft_rst_in=1: pc_out<=RESET_ADDR, jump_taken_out<=0, halted_out<=0, retired_out<=0, regardless of en_in.
REQ-020 en_in=0: pc_out, halted_out, retired_out hold; jump_taken_out<=0.
REQ-021 Load: pc_out<=target_in, jump_taken_out<=1, latency one clock.
REQ-022 Increment: pc_out<=pc_out+1 modulo 2^ADDR_W (all-ones wraps to 0), jump_taken_out<=0.
REQ-023 Halt: take with target_in==pc_out sets halted_out<=1 and jump_taken_out<=1; pc_out unchanged.
REQ-024 While halted_out=1: pc_out holds, jump_taken_out<=0, retired_out holds, inputs other than soft_rst_in ignored.
REQ-025 retired_out increments on every load, increment or halt-entry cycle; saturates at all-ones.
REQ-026 jump_bits_in ignored when is_c_inst_in=0 (A-instruction always increments).
REQ-027 Unconditional jump code 111 taken for any zr/ng combination.

Reset
REQ-028 rst_n_in low asynchronously forces pc_out=RESET_ADDR, jump_taken_out=0, halted_out=0, retired_out=0.
REQ-029 Release of rst_n_in: first edge with rst_n_in high applies REQ-018 normally; no extra dead cycle.
REQ-030 Async reset mid-halt or mid-stall clears all state identically to power-on.

Structure
REQ-031 Shared package hack_pkg holds ADDR_W default, jump-code enum (NULL,JGT,JEQ,JGE,JLT,JNE,JLE,JMP) and RESET_ADDR default.
REQ-032 Jump-condition decode (REQ-017) lives in sub-module hack_jump_cond, purely combinational; hack_pc holds all registers.
REQ-033 All outputs driven directly from flops; no combinational input-to-output path.

Verification
REQ-034 Reset then 5 cycles en_in=1, A-instructions -> pc_out 0,1,2,3,4,5; retired_out=5; jump_taken_out=0 throughout.
REQ-035 pc_out=0x0010, C-inst, jump 011 (JGE), zr=0 ng=1, target 0x0200 -> pc_out=0x0011; repeat with ng=0 -> pc_out=0x0200, jump_taken_out=1 one cycle.
REQ-036 pc_out=0x7FFF, increment -> pc_out=0x0000, jump_taken_out=0.
REQ-037 pc_out=0x0042, jump 111, target 0x0042 -> halted_out=1, pc_out stays 0x0042 for 10 further cycles; soft_rst_in -> pc_out=0, halted_out=0.
REQ-038 en_in=0 for 3 cycles with take=1 -> pc_out and retired_out unchanged, jump_taken_out=0; en_in=1 -> load occurs next edge.
REQ-039 rst_n_in pulsed low between edges while pc_out=0x1234, halted_out=1 -> outputs zero/RESET_ADDR immediately, before next edge.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack program counter.
// Jump codes, flag bit positions and parameter defaults.
package hack_pkg;

  localparam int          ADDR_W_DEF     = 15;
  localparam int unsigned RESET_ADDR_DEF = 0;
  localparam int          CNT_W_DEF      = 16;

  // j1 j2 j3 map to bits 2 1 0
  localparam int J_LT = 2;
  localparam int J_EQ = 1;
  localparam int J_GT = 0;

  typedef enum logic [2:0] {
    NULL = 3'b000,
    JGT  = 3'b001,
    JEQ  = 3'b010,
    JGE  = 3'b011,
    JLT  = 3'b100,
    JNE  = 3'b101,
    JLE  = 3'b110,
    JMP  = 3'b111
  } jump_e;

endpackage

// File: rtl/hack_pc_if.sv
// Control/status bundle between the Hack CPU core and its PC.
// master drives the request side, slave is the PC itself.
interface hack_pc_if #(
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 16
);

  logic              soft_rst_in;
  logic              en_in;
  logic              is_c_inst_in;
  logic [2:0]        jump_bits_in;
  logic              zr_in;
  logic              ng_in;
  logic [ADDR_W-1:0] target_in;
  logic [ADDR_W-1:0] pc_out;
  logic              jump_taken_out;
  logic              halted_out;
  logic [CNT_W-1:0]  retired_out;

  modport master (
    output soft_rst_in,
    output en_in,
    output is_c_inst_in,
    output jump_bits_in,
    output zr_in,
    output ng_in,
    output target_in,
    input  pc_out,
    input  jump_taken_out,
    input  halted_out,
    input  retired_out
  );

  modport slave (
    input  soft_rst_in,
    input  en_in,
    input  is_c_inst_in,
    input  jump_bits_in,
    input  zr_in,
    input  ng_in,
    input  target_in,
    output pc_out,
    output jump_taken_out,
    output halted_out,
    output retired_out
  );

endinterface

// File: rtl/hack_jump_cond.sv
// Hack jump-condition decode from j-bits and ALU flags.
// Purely combinational; A-instructions never jump.
module hack_jump_cond
  import hack_pkg::*;
(
  input  logic       is_c_inst,
  input  logic [2:0] jump_bits,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  logic pos;

  assign pos  = ~zr & ~ng;
  assign take = is_c_inst &
                ((jump_bits[J_LT] & ng) |
                 (jump_bits[J_EQ] & zr) |
                 (jump_bits[J_GT] & pos));

endmodule

// File: rtl/hack_pc.sv
// Hack program counter with jump, stall, self-loop halt
// detection and a saturating retired-instruction counter.
module hack_pc
  import hack_pkg::*;
#(
  parameter int          ADDR_W     = ADDR_W_DEF,
  parameter int unsigned RESET_ADDR = RESET_ADDR_DEF,
  parameter int          CNT_W      = CNT_W_DEF
) (
  input logic     clk_in,
  input logic     rst_n_in,
  hack_pc_if.slave bus
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_ADDR);

  logic [ADDR_W-1:0] pc_q;
  logic              jt_q;
  logic              halt_q;
  logic [CNT_W-1:0]  ret_q;

  logic              take;
  logic              self_loop;
  logic [CNT_W-1:0]  ret_inc;

  hack_jump_cond u_cond (
    .is_c_inst (bus.is_c_inst_in),
    .jump_bits (bus.jump_bits_in),
    .zr        (bus.zr_in),
    .ng        (bus.ng_in),
    .take      (take)
  );

  assign self_loop = (bus.target_in == pc_q);
  assign ret_inc   = (&ret_q) ? ret_q : ret_q + CNT_W'(1);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc_q   <= RST_PC;
      jt_q   <= 1'b0;
      halt_q <= 1'b0;
      ret_q  <= '0;
    end else if (bus.soft_rst_in) begin
      pc_q   <= RST_PC;
      jt_q   <= 1'b0;
      halt_q <= 1'b0;
      ret_q  <= '0;
    end else if (!bus.en_in || halt_q) begin
      jt_q <= 1'b0;
    end else if (take) begin
      // a jump onto itself is the Hack idiom for "program done"
      if (self_loop) halt_q <= 1'b1;
      else           pc_q   <= bus.target_in;
      jt_q  <= 1'b1;
      ret_q <= ret_inc;
    end else begin
      pc_q  <= pc_q + ADDR_W'(1);
      jt_q  <= 1'b0;
      ret_q <= ret_inc;
    end
  end

  assign bus.pc_out         = pc_q;
  assign bus.jump_taken_out = jt_q;
  assign bus.halted_out     = halt_q;
  assign bus.retired_out    = ret_q;

endmodule

// File: tb/tb_hack_pc.sv
// Directed-vector bench for hack_pc.
// Inputs change and outputs are sampled on the falling edge.
module tb_hack_pc;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  hack_pc_if #(.ADDR_W(15), .CNT_W(16)) bus ();

  hack_pc #(
    .ADDR_W     (15),
    .RESET_ADDR (0),
    .CNT_W      (16)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [31:0] pc,
                         input logic        jt,
                         input logic        h,
                         input logic [31:0] ret);
    chk({tag, ".pc"},  32'(bus.pc_out), pc);
    chk({tag, ".jt"},  32'(bus.jump_taken_out), 32'(jt));
    chk({tag, ".hlt"}, 32'(bus.halted_out), 32'(h));
    chk({tag, ".ret"}, 32'(bus.retired_out), ret);
  endtask

  task automatic drive(input logic c, input logic [2:0] jb,
                       input logic zr, input logic ng,
                       input logic [14:0] tgt);
    bus.is_c_inst_in = c;
    bus.jump_bits_in = jb;
    bus.zr_in        = zr;
    bus.ng_in        = ng;
    bus.target_in    = tgt;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        c;
    logic [2:0]  jb;
    logic        zr;
    logic        ng;
    logic [14:0] tgt;
    logic [14:0] pc;
    logic        jt;
  } vec_t;

  vec_t vecs[9];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0] = '{1'b0, 3'b111, 1'b0, 1'b0, 15'h0300, 15'h0202, 1'b0};
    vecs[1] = '{1'b1, 3'b100, 1'b0, 1'b1, 15'h0300, 15'h0300, 1'b1};
    vecs[2] = '{1'b1, 3'b101, 1'b1, 1'b0, 15'h0400, 15'h0301, 1'b0};
    vecs[3] = '{1'b1, 3'b010, 1'b1, 1'b0, 15'h0400, 15'h0400, 1'b1};
    vecs[4] = '{1'b1, 3'b110, 1'b0, 1'b0, 15'h0500, 15'h0401, 1'b0};
    vecs[5] = '{1'b1, 3'b111, 1'b1, 1'b1, 15'h0500, 15'h0500, 1'b1};
    vecs[6] = '{1'b1, 3'b000, 1'b1, 1'b1, 15'h0600, 15'h0501, 1'b0};
    vecs[7] = '{1'b1, 3'b001, 1'b0, 1'b0, 15'h7fff, 15'h7fff, 1'b1};
    vecs[8] = '{1'b0, 3'b000, 1'b0, 1'b0, 15'h0000, 15'h0000, 1'b0};

    rst_n = 1'b0;
    bus.soft_rst_in = 1'b0;
    bus.en_in       = 1'b1;
    drive(1'b0, 3'b000, 1'b0, 1'b0, 15'h0);
    #1 chk_all("por", 0, 0, 0, 0);

    @(negedge clk);
    rst_n = 1'b1;
    chk("seq0.pc", 32'(bus.pc_out), 0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("seq.pc", 32'(bus.pc_out), 32'(i));
      chk("seq.jt", 32'(bus.jump_taken_out), 0);
    end
    chk("seq.ret", 32'(bus.retired_out), 5);

    // JGE not taken on negative, taken on positive
    drive(1'b1, 3'b111, 1'b0, 1'b0, 15'h0010);
    step(); chk_all("jmp10", 32'h10, 1, 0, 6);
    drive(1'b1, 3'b011, 1'b0, 1'b1, 15'h0200);
    step(); chk_all("jge_n", 32'h11, 0, 0, 7);
    drive(1'b1, 3'b011, 1'b0, 1'b0, 15'h0200);
    step(); chk_all("jge_p", 32'h200, 1, 0, 8);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 15'h0);
    step(); chk_all("after", 32'h201, 0, 0, 9);

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].c, vecs[i].jb, vecs[i].zr, vecs[i].ng, vecs[i].tgt);
      step();
      chk($sformatf("vec%0d.pc", i), 32'(bus.pc_out), 32'(vecs[i].pc));
      chk($sformatf("vec%0d.jt", i), 32'(bus.jump_taken_out),
          32'(vecs[i].jt));
    end
    chk("vec.ret", 32'(bus.retired_out), 18);

    bus.en_in = 1'b0;
    drive(1'b1, 3'b111, 1'b0, 1'b0, 15'h0100);
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("stall", 0, 0, 0, 18);
    end
    bus.en_in = 1'b1;
    step(); chk_all("unstall", 32'h100, 1, 0, 19);

    drive(1'b1, 3'b111, 1'b0, 1'b0, 15'h0042);
    step(); chk_all("to42", 32'h42, 1, 0, 20);
    step(); chk_all("halt", 32'h42, 1, 1, 21);
    drive(1'b0, 3'b000, 1'b0, 1'b1, 15'h0777);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) drive(1'b1, 3'b111, 1'b0, 1'b0, 15'h0777);
      step(); chk_all("halted", 32'h42, 0, 1, 21);
    end
    bus.soft_rst_in = 1'b1;
    bus.en_in       = 1'b0;
    step(); chk_all("srst", 0, 0, 0, 0);
    bus.soft_rst_in = 1'b0;
    bus.en_in       = 1'b1;

    drive(1'b1, 3'b111, 1'b0, 1'b0, 15'h1234);
    step(); chk_all("to1234", 32'h1234, 1, 0, 1);
    step(); chk_all("halt2", 32'h1234, 1, 1, 2);
    #2 rst_n = 1'b0;
    #1 chk_all("arst", 0, 0, 0, 0);
    #1 rst_n = 1'b1;
    drive(1'b0, 3'b000, 1'b0, 1'b0, 15'h0);
    step(); chk_all("rel", 1, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
